// File: rtl/hv_desat_flt_det_if.sv
// Signal bundle between the HV config/gate-command side and the DESAT detector.
// master drives config/commands and observes status; slave is the detector.
interface hv_desat_flt_det_if;
  logic       desat_dig_en;
  logic [2:0] desat_blanking;
  logic [2:0] desat_deglitch_sel;
  logic       pwm_on;
  logic       desat_cmp;
  logic       flt_clr;
  logic       blank_active;
  logic       desat_flt;
  logic       desat_flt_pulse;
  logic [1:0] desat_st;

  modport master (
    output desat_dig_en, desat_blanking, desat_deglitch_sel, pwm_on, desat_cmp, flt_clr,
    input  blank_active, desat_flt, desat_flt_pulse, desat_st
  );

  modport slave (
    input  desat_dig_en, desat_blanking, desat_deglitch_sel, pwm_on, desat_cmp, flt_clr,
    output blank_active, desat_flt, desat_flt_pulse, desat_st
  );
endinterface

// File: rtl/hv_desat_flt_det.sv
// DESAT fault detector: blanking after gate turn-on, consecutive-sample deglitch
// of the synchronized comparator, and a sticky fault cleared only with the gate off.
module hv_desat_flt_det #(
  parameter int unsigned BLANK_UNIT = 16,
  parameter int unsigned DGL_UNIT   = 4,
  parameter int unsigned CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  hv_desat_flt_det_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    MON   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] r_blank_len;
  logic [CNT_W-1:0] r_dgl_len;
  logic [CNT_W-1:0] w_blank_len;
  logic [CNT_W-1:0] w_dgl_len;
  logic             r_cmp_meta;
  logic             r_cmp_s;
  logic             r_flt_pulse;
  logic             w_run;
  logic             w_blank_active;
  logic             w_desat_flt;

  assign w_run       = bus.pwm_on & bus.desat_dig_en;
  assign w_blank_len = CNT_W'(BLANK_UNIT) * (CNT_W'(bus.desat_blanking) + CNT_W'(1));
  assign w_dgl_len   = CNT_W'(DGL_UNIT) * (CNT_W'(bus.desat_deglitch_sel) + CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_blank_len <= '0;
      r_dgl_len   <= '0;
      r_cmp_meta  <= 1'b0;
      r_cmp_s     <= 1'b0;
      r_flt_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_cmp_meta  <= bus.desat_cmp;
      r_cmp_s     <= r_cmp_meta;
      r_flt_pulse <= (w_state_nx == FAULT) && (r_state != FAULT);
      if (r_state == IDLE && w_state_nx == BLANK) begin
        r_blank_len <= w_blank_len;
        r_dgl_len   <= w_dgl_len;
      end
    end
  end

  // Every state change clears the shared counter; turn-off beats fault detection in MON.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    case (r_state)
      IDLE: begin
        if (w_run) w_state_nx = BLANK;
      end
      BLANK: begin
        if (!w_run) w_state_nx = IDLE;
        else if (r_cnt == r_blank_len - CNT_W'(1)) w_state_nx = MON;
        else w_cnt_nx = r_cnt + CNT_W'(1);
      end
      MON: begin
        if (!w_run) w_state_nx = IDLE;
        else if (r_cmp_s && (r_cnt == r_dgl_len - CNT_W'(1))) w_state_nx = FAULT;
        else if (r_cmp_s) w_cnt_nx = r_cnt + CNT_W'(1);
      end
      FAULT: begin
        if (bus.flt_clr && !bus.pwm_on) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_blank_active = (r_state == BLANK);
    w_desat_flt    = (r_state == FAULT);
  end

  assign bus.blank_active    = w_blank_active;
  assign bus.desat_flt       = w_desat_flt;
  assign bus.desat_flt_pulse = r_flt_pulse;
  assign bus.desat_st        = r_state;

endmodule

// File: doc/hv_desat_flt_det.md
# hv_desat_flt_det

HV-side desaturation fault detector: the digital stage that consumes the DESAT configuration fields (`desat_dig_en`, `desat_blanking`, `desat_deglitch_sel`) held in the HV config registers and turns the analog DESAT comparator output into a qualified, latched fault.

- Applies a configurable blanking window after each gate turn-on command.
- Deglitches the comparator with a consecutive-sample filter.
- Reports a sticky fault to the HV fault/shutdown logic and the status registers.

## Interface
Parameters:
- `BLANK_UNIT`, 16: clock cycles per blanking step.
- `DGL_UNIT`, 4: clock cycles per deglitch step.
- `CNT_W`, 10: counter width. Legal only if `8*BLANK_UNIT` and `8*DGL_UNIT` are both < 2^`CNT_W`.

Ports:
- `clk`  in  1  block clock. One clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `desat_dig_en`  in  1  detector enable (config6).
- `desat_blanking`  in  3  blanking select (config6).
- `desat_deglitch_sel`  in  3  deglitch select (config7).
- `pwm_on`  in  1  gate-on command, synchronous to `clk`.
- `desat_cmp`  in  1  raw analog comparator output, asynchronous. 1 = desaturated.
- `flt_clr`  in  1  single-cycle fault clear request.
- `blank_active`  out  1  high while in BLANK. Drives the analog DESAT capacitor discharge switch.
- `desat_flt`  out  1  latched fault.
- `desat_flt_pulse`  out  1  one-cycle pulse on the cycle `desat_flt` rises.
- `desat_st`  out  2  FSM state for debug: IDLE=0, BLANK=1, MON=2, FAULT=3.

## Operation
- **Synchronizer:** `desat_cmp` passes through a 2-flop synchronizer; `cmp_s` is the synchronized value. Both flops reset to 0.
- **Shadowing:** on IDLE->BLANK, latch the thresholds into shadow registers. Config changes mid-cycle have no effect until the next BLANK entry.
  - `blank_len = BLANK_UNIT*(desat_blanking+1)`, range 16..128 cycles at default parameters.
  - `dgl_len = DGL_UNIT*(desat_deglitch_sel+1)`, range 4..32 cycles at default parameters.
- **FSM:**
  - IDLE:
    - `pwm_on=1` and `desat_dig_en=1` -> BLANK. Clear `cnt`, load shadows.
  - BLANK:
    - `cnt` increments every cycle; `cmp_s` is ignored.
    - `pwm_on=0` or `desat_dig_en=0` -> IDLE.
    - Otherwise, when `cnt==blank_len-1` -> MON with `cnt` cleared.
  - MON:
    - `cmp_s=1` increments `cnt`; `cmp_s=0` clears `cnt`. The count is of consecutive high samples.
    - `pwm_on=0` or `desat_dig_en=0` -> IDLE. This exit has priority over fault detection in the same cycle.
    - Otherwise, when `cmp_s=1` and `cnt==dgl_len-1` -> FAULT.
  - FAULT:
    - `desat_flt=1`.
    - Leaves only on `flt_clr=1` with `pwm_on=0` -> IDLE.
    - `flt_clr` while `pwm_on=1` is ignored and not remembered.
    - `desat_dig_en` has no effect in FAULT.
- **Counter:** one shared `CNT_W`-bit counter, cleared on every state change. It never wraps under legal parameters.
- **Outputs:** all outputs are registered or decoded from the state register.
  - `blank_active = (state==BLANK)`.
  - `desat_flt = (state==FAULT)`.
  - `desat_flt_pulse` is registered and high for exactly the first FAULT cycle.

## Timing
- **Reset values:** state=IDLE, `cnt`=0, shadows=0, `blank_active`=0, `desat_flt`=0, `desat_flt_pulse`=0, `desat_st`=0. Reset mid-operation, including in FAULT, returns to these values on the next edge.
- **Blanking:**
  - `pwm_on` sampled high in IDLE at edge k -> `blank_active=1` from k+1.
  - BLANK lasts exactly `blank_len` cycles; MON begins at k+1+`blank_len`.
- **Comparator path:** 2 synchronizer cycles, then `dgl_len` consecutive high `cmp_s` samples. `desat_flt` rises on the edge that samples the `dgl_len`-th high sample.
- **Fault latency:** with `desat_cmp` steady high from MON entry, `desat_flt` rises `dgl_len`+2 cycles after the first MON cycle. A raw high pulse of `dgl_len`-1 cycles never faults.
- **Clear:** `flt_clr` with `pwm_on=0` at edge m -> `desat_flt=0` at m+1.
  - If `pwm_on` is still 0, re-entry to BLANK takes at least one IDLE cycle.
  - If `flt_clr` and `pwm_on=1` arrive together, the clear is ignored.
- **Turn-off:** `pwm_on` falling in BLANK or MON -> IDLE next edge. `blank_active` drops in the same edge.

## Test plan
All scenarios use `BLANK_UNIT=16`, `DGL_UNIT=4`.
- **Blanking masks comparator:** `desat_blanking=0`, `desat_cmp=1` only during the first 15 BLANK cycles -> `blank_active` high for exactly 16 cycles, `desat_flt` stays 0.
- **Deglitch boundary:** `desat_deglitch_sel=2` (`dgl_len`=12).
  - In MON, a raw 11-cycle high pulse -> no fault.
  - A 12-cycle high pulse -> `desat_flt`=1 plus a single `desat_flt_pulse`, 14 cycles after the pulse starts.
- **Clear rules:**
  - In FAULT, `flt_clr` with `pwm_on=1` -> fault held.
  - Drop `pwm_on`, pulse `flt_clr` -> `desat_flt`=0 next cycle, `desat_st`=0.
- **Enable/turn-off priority:**
  - `desat_dig_en=0` with `pwm_on=1`, `desat_cmp=1` -> state stays IDLE, no fault.
  - `pwm_on` falling on the same cycle the deglitch threshold is reached -> IDLE, no fault.
- **Config shadowing:** change `desat_blanking` from 0 to 7 mid-BLANK -> current window stays 16 cycles; the next window is 128 cycles.
- **Reset mid-operation:** assert `rst` in MON with `cnt`=5 and again in FAULT -> all outputs at reset values next cycle; a subsequent `pwm_on` restarts the full blanking window.
